// File: rtl/csr_bank_pkg.sv
// Shared CSR definitions: operation encodings, address map constants and
// the read-modify-write helper used by the CSR bank.
package csr_bank_pkg;

  typedef enum logic [1:0] {
    CSR_OP_READ = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  // Which storage element an address resolves to; read-only shadows resolve
  // to the same counter half as their machine-mode counterpart.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_SCRATCH,
    SEL_CYC_LO,
    SEL_CYC_HI,
    SEL_RET_LO,
    SEL_RET_HI
  } csr_sel_e;

  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  // New CSR value produced by an operation on the old value.
  function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old_val,
                                            logic [31:0] wdata);
    logic [31:0] res;
    res = old_val;
    case (op)
      CSR_OP_RW: res = wdata;
      CSR_OP_RS: res = old_val | wdata;
      CSR_OP_RC: res = old_val & ~wdata;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_bank_if.sv
// CSR request/response bus between the pipeline and the CSR bank.
interface csr_bank_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic [1:0]      req_op;
  logic [11:0]     req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            req_nowrite;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_illegal;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_nowrite,
    input  rsp_valid, rsp_rdata, rsp_illegal
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_nowrite,
    output rsp_valid, rsp_rdata, rsp_illegal
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit counter with increment enable and independent 32-bit half writes.
// A write to either half suppresses the increment (and carry) that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  // Software writes take priority over counting; unwritten half holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) value[31:0]  <= wdata;
      if (wr_hi) value[63:32] <= wdata;
    end else if (inc_en) begin
      value <= value + 64'd1;
    end
  end

endmodule

// File: rtl/csr_bank.sv
// Machine CSR bank: scratch registers plus 64-bit cycle/instret counters,
// with a single-cycle registered response carrying the pre-write value.
// Only XLEN = 32 is supported.
module csr_bank
  import csr_bank_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter int          NUM_SCRATCH  = 4,
  parameter logic [11:0] SCRATCH_BASE = 12'h7C0
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    retire,
  csr_bank_if.slave bus
);

  logic [XLEN-1:0]        scratch [NUM_SCRATCH];
  logic [NUM_SCRATCH-1:0] scratch_hit;
  logic [63:0]            mcycle;
  logic [63:0]            minstret;
  csr_sel_e               sel;
  csr_op_e                op;
  logic [XLEN-1:0]        old_val;
  logic [XLEN-1:0]        new_val;
  logic                   write_req;
  logic                   illegal;
  logic                   do_write;

  assign op = csr_op_e'(bus.req_op);

  // Address decode and pre-write read mux.
  always_comb begin
    sel         = SEL_NONE;
    scratch_hit = '0;
    old_val     = '0;
    for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
      if (bus.req_addr == 12'(SCRATCH_BASE + 12'(i))) begin
        sel            = SEL_SCRATCH;
        scratch_hit[i] = 1'b1;
        old_val        = scratch[i];
      end
    end
    case (bus.req_addr)
      CSR_MCYCLE, CSR_CYCLE: begin
        sel     = SEL_CYC_LO;
        old_val = mcycle[31:0];
      end
      CSR_MCYCLEH, CSR_CYCLEH: begin
        sel     = SEL_CYC_HI;
        old_val = mcycle[63:32];
      end
      CSR_MINSTRET, CSR_INSTRET: begin
        sel     = SEL_RET_LO;
        old_val = minstret[31:0];
      end
      CSR_MINSTRETH, CSR_INSTRETH: begin
        sel     = SEL_RET_HI;
        old_val = minstret[63:32];
      end
      default: ;
    endcase
  end

  // Legality and write enable; RS/RC with a zero operand still count as writes.
  always_comb begin
    write_req = (op != CSR_OP_READ) && !bus.req_nowrite;
    illegal   = (sel == SEL_NONE) || (write_req && (bus.req_addr[11:10] == 2'b11));
    do_write  = bus.req_valid && !illegal && write_req;
    new_val   = csr_apply(op, old_val, bus.req_wdata);
  end

  csr_counter64 u_mcycle (
    .clk    (clk),
    .rst    (rst),
    .inc_en (1'b1),
    .wr_lo  (do_write && (sel == SEL_CYC_LO)),
    .wr_hi  (do_write && (sel == SEL_CYC_HI)),
    .wdata  (new_val),
    .value  (mcycle)
  );

  csr_counter64 u_minstret (
    .clk    (clk),
    .rst    (rst),
    .inc_en (retire),
    .wr_lo  (do_write && (sel == SEL_RET_LO)),
    .wr_hi  (do_write && (sel == SEL_RET_HI)),
    .wdata  (new_val),
    .value  (minstret)
  );

  // Scratch register file update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
        if (do_write && scratch_hit[i]) scratch[i] <= new_val;
      end
    end
  end

  // Registered response; illegal requests return zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_illegal <= 1'b0;
    end else begin
      bus.rsp_valid   <= bus.req_valid;
      bus.rsp_illegal <= bus.req_valid && illegal;
      bus.rsp_rdata   <= (bus.req_valid && !illegal) ? old_val : '0;
    end
  end

endmodule

// File: tb/tb_csr_bank.sv
// Directed self-checking bench for csr_bank.
module tb_csr_bank;
  import csr_bank_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic retire;
  int   passed = 0;
  int   total  = 0;

  logic        got_valid;
  logic [31:0] got_rdata;
  logic        got_ill;

  csr_bank_if #(.XLEN(32)) bus ();

  csr_bank #(
    .XLEN         (32),
    .NUM_SCRATCH  (4),
    .SCRATCH_BASE (12'h7C0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .retire (retire),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Called at a negedge: presents one request for one cycle and captures the
  // response at the following negedge. Consecutive calls are back-to-back.
  task automatic issue(input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] wd, input logic nw);
    bus.req_valid   = 1'b1;
    bus.req_op      = op;
    bus.req_addr    = addr;
    bus.req_wdata   = wd;
    bus.req_nowrite = nw;
    @(negedge clk);
    got_valid       = bus.rsp_valid;
    got_rdata       = bus.rsp_rdata;
    got_ill         = bus.rsp_illegal;
    bus.req_valid   = 1'b0;
    bus.req_wdata   = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.rsp_valid); else passed++;
    total++; if (bus.rsp_rdata !== 32'h0) $display("FAIL reset_rdata got %h exp 0", bus.rsp_rdata); else passed++;
    total++; if (bus.rsp_illegal !== 1'b0) $display("FAIL reset_illegal got %b exp 0", bus.rsp_illegal); else passed++;
    rst = 1'b0;
    issue(CSR_OP_READ, 12'hB00, '0, 1'b1);
    total++; if (got_valid !== 1'b1) $display("FAIL reset_mcycle_valid got %b exp 1", got_valid); else passed++;
    total++; if (got_rdata !== 32'h0) $display("FAIL reset_mcycle got %h exp 0", got_rdata); else passed++;
    issue(CSR_OP_READ, 12'hB02, '0, 1'b1);
    total++; if (got_rdata !== 32'h0) $display("FAIL reset_minstret got %h exp 0", got_rdata); else passed++;
    for (int i = 0; i < 4; i++) begin
      issue(CSR_OP_READ, 12'(12'h7C0 + i), '0, 1'b1);
      total++; if (got_rdata !== 32'h0 || got_ill !== 1'b0) $display("FAIL reset_scratch%0d got %h/%b exp 0/0", i, got_rdata, got_ill); else passed++;
    end
  endtask

  task automatic test_scratch_rw();
    issue(CSR_OP_RW, 12'h7C1, 32'hDEAD_BEEF, 1'b0);
    total++; if (got_rdata !== 32'h0) $display("FAIL rw_old got %h exp 0", got_rdata); else passed++;
    issue(CSR_OP_READ, 12'h7C1, '0, 1'b1);
    total++; if (got_rdata !== 32'hDEAD_BEEF) $display("FAIL rw_read got %h exp deadbeef", got_rdata); else passed++;
    total++; if (got_ill !== 1'b0) $display("FAIL rw_illegal got %b exp 0", got_ill); else passed++;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL idle_valid got %b exp 0", bus.rsp_valid); else passed++;
  endtask

  task automatic test_set_clear();
    issue(CSR_OP_RW, 12'h7C0, 32'h0000_00F0, 1'b0);
    issue(CSR_OP_RS, 12'h7C0, 32'h0000_000F, 1'b0);
    total++; if (got_rdata !== 32'hF0) $display("FAIL rs_old got %h exp f0", got_rdata); else passed++;
    issue(CSR_OP_RC, 12'h7C0, 32'h0000_00F0, 1'b0);
    total++; if (got_rdata !== 32'hFF) $display("FAIL rc_old got %h exp ff", got_rdata); else passed++;
    issue(CSR_OP_RS, 12'h7C0, 32'h0, 1'b0);
    total++; if (got_rdata !== 32'h0F || got_ill !== 1'b0) $display("FAIL rs_zero got %h/%b exp 0f/0", got_rdata, got_ill); else passed++;
    issue(CSR_OP_READ, 12'h7C0, '0, 1'b1);
    total++; if (got_rdata !== 32'h0F) $display("FAIL setclr_final got %h exp 0f", got_rdata); else passed++;
  endtask

  task automatic test_readonly();
    issue(CSR_OP_RW, 12'hB00, 32'h0000_1000, 1'b0);
    issue(CSR_OP_RS, 12'hC00, 32'h0, 1'b0);
    total++; if (got_ill !== 1'b1 || got_rdata !== 32'h0) $display("FAIL ro_rs_zero got %b/%h exp 1/0", got_ill, got_rdata); else passed++;
    issue(CSR_OP_RW, 12'hC00, 32'h5, 1'b0);
    total++; if (got_ill !== 1'b1 || got_rdata !== 32'h0) $display("FAIL ro_rw got %b/%h exp 1/0", got_ill, got_rdata); else passed++;
    total++; if (got_valid !== 1'b1) $display("FAIL ro_rw_valid got %b exp 1", got_valid); else passed++;
    issue(CSR_OP_RW, 12'hC00, 32'h5, 1'b1);
    total++; if (got_ill !== 1'b0 || got_rdata !== 32'h0000_1002) $display("FAIL ro_nowrite got %b/%h exp 0/00001002", got_ill, got_rdata); else passed++;
  endtask

  task automatic test_mcycle_carry();
    issue(CSR_OP_RW, 12'hB00, 32'hFFFF_FFFF, 1'b0);
    issue(CSR_OP_RW, 12'hB80, 32'h0, 1'b0);
    @(negedge clk);
    issue(CSR_OP_READ, 12'hB00, '0, 1'b1);
    total++; if (got_rdata !== 32'h0) $display("FAIL carry_lo got %h exp 0", got_rdata); else passed++;
    issue(CSR_OP_READ, 12'hB80, '0, 1'b1);
    total++; if (got_rdata !== 32'h1) $display("FAIL carry_hi got %h exp 1", got_rdata); else passed++;
    issue(CSR_OP_RW, 12'hB00, 32'hFFFF_FFFF, 1'b0);
    issue(CSR_OP_RW, 12'hB80, 32'hFFFF_FFFF, 1'b0);
    issue(CSR_OP_READ, 12'hB00, '0, 1'b1);
    total++; if (got_rdata !== 32'hFFFF_FFFF) $display("FAIL wrap_lo_pre got %h exp ffffffff", got_rdata); else passed++;
    issue(CSR_OP_READ, 12'hC80, '0, 1'b1);
    total++; if (got_rdata !== 32'h0) $display("FAIL wrap_hi got %h exp 0", got_rdata); else passed++;
    issue(CSR_OP_READ, 12'hC00, '0, 1'b1);
    total++; if (got_rdata !== 32'h1) $display("FAIL wrap_lo got %h exp 1", got_rdata); else passed++;
  endtask

  task automatic test_minstret_write();
    retire = 1'b1;
    issue(CSR_OP_RW, 12'hB02, 32'h5, 1'b0);
    retire = 1'b0;
    issue(CSR_OP_READ, 12'hB02, '0, 1'b1);
    total++; if (got_rdata !== 32'h5) $display("FAIL instret_write got %h exp 5", got_rdata); else passed++;
  endtask

  task automatic test_unmapped();
    issue(CSR_OP_READ, 12'h7C4, '0, 1'b1);
    total++; if (got_ill !== 1'b1 || got_rdata !== 32'h0) $display("FAIL unmapped_read got %b/%h exp 1/0", got_ill, got_rdata); else passed++;
    issue(CSR_OP_RW, 12'h7C4, 32'h1234_5678, 1'b0);
    total++; if (got_ill !== 1'b1) $display("FAIL unmapped_write got %b exp 1", got_ill); else passed++;
    issue(CSR_OP_RW, 12'h300, 32'h1, 1'b0);
    total++; if (got_ill !== 1'b1) $display("FAIL unmapped_300 got %b exp 1", got_ill); else passed++;
    issue(CSR_OP_READ, 12'h7C0, '0, 1'b1);
    total++; if (got_rdata !== 32'h0F) $display("FAIL keep_s0 got %h exp 0f", got_rdata); else passed++;
    issue(CSR_OP_READ, 12'h7C1, '0, 1'b1);
    total++; if (got_rdata !== 32'hDEAD_BEEF) $display("FAIL keep_s1 got %h exp deadbeef", got_rdata); else passed++;
    issue(CSR_OP_READ, 12'h7C2, '0, 1'b1);
    total++; if (got_rdata !== 32'h0) $display("FAIL keep_s2 got %h exp 0", got_rdata); else passed++;
    issue(CSR_OP_READ, 12'h7C3, '0, 1'b1);
    total++; if (got_rdata !== 32'h0) $display("FAIL keep_s3 got %h exp 0", got_rdata); else passed++;
  endtask

  task automatic test_retire_reset();
    issue(CSR_OP_RW, 12'hB02, 32'h0, 1'b0);
    retire = 1'b1;
    repeat (10) @(negedge clk);
    retire = 1'b0;
    issue(CSR_OP_READ, 12'hC02, '0, 1'b1);
    total++; if (got_rdata !== 32'd10) $display("FAIL instret_10 got %0d exp 10", got_rdata); else passed++;
    issue(CSR_OP_READ, 12'hC82, '0, 1'b1);
    total++; if (got_rdata !== 32'h0) $display("FAIL instreth got %h exp 0", got_rdata); else passed++;
    bus.req_valid = 1'b1;
    bus.req_op    = CSR_OP_READ;
    bus.req_addr  = 12'h7C1;
    #1 rst = 1'b1;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_drop_valid got %b exp 0", bus.rsp_valid); else passed++;
    total++; if (bus.rsp_rdata !== 32'h0) $display("FAIL rst_drop_rdata got %h exp 0", bus.rsp_rdata); else passed++;
    bus.req_valid = 1'b0;
    rst = 1'b0;
    issue(CSR_OP_READ, 12'hB00, '0, 1'b1);
    total++; if (got_rdata !== 32'h0) $display("FAIL post_rst_mcycle got %h exp 0", got_rdata); else passed++;
    issue(CSR_OP_READ, 12'hB02, '0, 1'b1);
    total++; if (got_rdata !== 32'h0) $display("FAIL post_rst_minstret got %h exp 0", got_rdata); else passed++;
    issue(CSR_OP_READ, 12'hB80, '0, 1'b1);
    total++; if (got_rdata !== 32'h0) $display("FAIL post_rst_mcycleh got %h exp 0", got_rdata); else passed++;
    issue(CSR_OP_READ, 12'hB82, '0, 1'b1);
    total++; if (got_rdata !== 32'h0) $display("FAIL post_rst_minstreth got %h exp 0", got_rdata); else passed++;
    issue(CSR_OP_READ, 12'h7C1, '0, 1'b1);
    total++; if (got_rdata !== 32'h0) $display("FAIL post_rst_scratch got %h exp 0", got_rdata); else passed++;
  endtask

  initial begin
    rst             = 1'b1;
    retire          = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_op      = 2'b00;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.req_nowrite = 1'b0;
    test_reset();
    test_scratch_rw();
    test_set_clear();
    test_readonly();
    test_mcycle_carry();
    test_minstret_write();
    test_unmapped();
    test_retire_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
